// File: rtl/frame_loader.sv
// Byte-stream frame assembler: builds an LENGTH x WIDTH x 3 image and pulses init_out when complete.
// Optional `FRAME_CHECKSUM_EN adds a trailing modulo-256 checksum byte checked before completion.
module frame_loader #(
   parameter int LENGTH      = 32,
   parameter int WIDTH       = 32,
   parameter int HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   input  logic        byte_sof,
   output logic        byte_ready,
   output logic [7:0]  image [LENGTH-1:0][WIDTH-1:0][2:0],
   output logic        init_out,
   output logic        frame_err,
   output logic [15:0] frame_cnt
);

   localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef FRAME_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_HOLD} state_t;
   logic [7:0] sum_q, sum_d;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_HOLD} state_t;
`endif

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [1:0]      ch_q, ch_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            err_q, err_d;
   logic [7:0]      image_q [LENGTH-1:0][WIDTH-1:0][2:0];
   logic [7:0]      image_d [LENGTH-1:0][WIDTH-1:0][2:0];
   logic            accept, last, do_start;

`ifdef FRAME_CHECKSUM_EN
   assign byte_ready = !rst && (state_q == S_IDLE || state_q == S_LOAD || state_q == S_CHECK);
`else
   assign byte_ready = !rst && (state_q == S_IDLE || state_q == S_LOAD);
`endif
   assign accept    = byte_valid && byte_ready;
   assign last      = (row_q == RW'(LENGTH-1)) && (col_q == CW'(WIDTH-1)) && (ch_q == 2'd2);
   assign init_out  = !rst && (state_q == S_DONE);
   assign frame_err = !rst && err_q;
   assign frame_cnt = rst ? 16'd0 : cnt_q;
   assign image     = image_q;

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      ch_d     = ch_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      image_d  = image_q;
      do_start = 1'b0;
`ifdef FRAME_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept && byte_sof) do_start = 1'b1;
         end
         S_LOAD: begin
            if (accept && byte_sof) begin
               err_d    = 1'b1;
               do_start = 1'b1;
            end else if (accept) begin
               image_d[row_q][col_q][ch_q] = byte_in;
`ifdef FRAME_CHECKSUM_EN
               sum_d = sum_q + byte_in;
`endif
               // Counters stay parked on the last position so a sof in CHECK still sees index != 0.
               if (last) begin
`ifdef FRAME_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_DONE;
`endif
               end else if (ch_q == 2'd2) begin
                  ch_d = 2'd0;
                  if (col_q == CW'(WIDTH-1)) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end
         end
`ifdef FRAME_CHECKSUM_EN
         S_CHECK: begin
            if (accept && byte_sof) begin
               err_d    = 1'b1;
               do_start = 1'b1;
            end else if (accept) begin
               if (byte_in == sum_q) begin
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
`endif
         S_DONE: begin
            cnt_d   = cnt_q + 16'd1;
            hold_d  = '0;
            state_d = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            if (int'(hold_q) >= HOLD_CYCLES - 1) state_d = S_IDLE;
            else hold_d = hold_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (do_start) begin
         image_d[0][0][0] = byte_in;
         row_d   = '0;
         col_d   = '0;
         ch_d    = 2'd1;
         state_d = S_LOAD;
`ifdef FRAME_CHECKSUM_EN
         sum_d   = byte_in;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         ch_q    <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
         sum_q   <= '0;
`endif
         for (int i = 0; i < LENGTH; i++)
            for (int j = 0; j < WIDTH; j++)
               for (int c = 0; c < 3; c++)
                  image_q[i][j][c] <= 8'h00;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         ch_q    <= ch_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef FRAME_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
         image_q <= image_d;
      end
   end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader at LENGTH=2, WIDTH=2, HOLD_CYCLES=4.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_frame_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_sof;
   logic        byte_ready;
   logic [7:0]  image [1:0][1:0][2:0];
   logic        init_out;
   logic        frame_err;
   logic [15:0] frame_cnt;

   int checks = 0;
   int fails  = 0;

   frame_loader #(.LENGTH(2), .WIDTH(2), .HOLD_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_sof   (byte_sof),
      .byte_ready (byte_ready),
      .image      (image),
      .init_out   (init_out),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the byte was accepted.
   task automatic send(input logic [7:0] b, input logic s);
      int n = 0;
      byte_in    = b;
      byte_sof   = s;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         fails++;
         $display("FAIL send_timeout observed=ready_low expected=ready_high");
      end
      @(negedge clk);
   endtask

   task automatic send_seq(input logic [7:0] base, input int n, input logic first_sof, input bit gaps);
      for (int i = 0; i < n; i++) begin
         send(8'(base + i), first_sof && (i == 0));
         if (gaps && i < n - 1) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
   endtask

   task automatic tail(input logic [7:0] ck);
`ifdef FRAME_CHECKSUM_EN
      send(ck, 1'b0);
`else
      if (ck == 8'h00) byte_sof = 1'b0;
`endif
   endtask

   task automatic do_reset();
      byte_valid = 1'b0;
      byte_sof   = 1'b0;
      rst        = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [7:0] image_or();
      logic [7:0] acc = 8'h00;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            for (int c = 0; c < 3; c++)
               acc |= image[i][j][c];
      return acc;
   endfunction

   initial begin
      int low_cnt;
      rst        = 1'b1;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      byte_sof   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", byte_ready, 1'b0);
      chk("rst_init", init_out, 1'b0);
      chk("rst_err", frame_err, 1'b0);
      chk("rst_cnt", frame_cnt, 16'd0);
      chk("rst_image", image_or(), 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", byte_ready, 1'b1);

      // Back-to-back frame 0x01..0x0C
      send_seq(8'h01, 11, 1'b1, 1'b0);
      chk("f1_init_early", init_out, 1'b0);
      send(8'h0C, 1'b0);
      tail(8'h4E);
      chk("f1_init", init_out, 1'b1);
      chk("f1_ready_done", byte_ready, 1'b0);
      byte_valid = 1'b0;
      @(negedge clk);
      chk("f1_init_one_cycle", init_out, 1'b0);
      chk("f1_cnt", frame_cnt, 16'd1);
      chk("f1_img000", image[0][0][0], 8'h01);
      chk("f1_img001", image[0][0][1], 8'h02);
      chk("f1_img002", image[0][0][2], 8'h03);
      chk("f1_img010", image[0][1][0], 8'h04);
      chk("f1_img102", image[1][0][2], 8'h09);
      chk("f1_img110", image[1][1][0], 8'h0A);
      chk("f1_img111", image[1][1][1], 8'h0B);
      chk("f1_img112", image[1][1][2], 8'h0C);

      // Frame with gaps; valid held afterwards with a sof byte that must not be consumed during DONE/HOLD
      send_seq(8'h21, 12, 1'b1, 1'b1);
      tail(8'hCE);
      byte_in    = 8'hEE;
      byte_sof   = 1'b1;
      byte_valid = 1'b1;
      low_cnt    = 0;
      while (!byte_ready && low_cnt < 20) begin
         low_cnt++;
         @(negedge clk);
      end
      chk("f2_ready_low_cycles", low_cnt, 5);
      chk("f2_cnt", frame_cnt, 16'd2);
      chk("f2_img000_held", image[0][0][0], 8'h21);
      chk("f2_img112_held", image[1][1][2], 8'h2C);
      byte_valid = 1'b0;
      @(negedge clk);
      chk("f2_img000_unconsumed", image[0][0][0], 8'h21);
      chk("f2_err_none", frame_err, 1'b0);

      // Early sof on byte 6 restarts the frame
      do_reset();
      send_seq(8'h31, 6, 1'b1, 1'b0);
      chk("f3_err_before", frame_err, 1'b0);
      send(8'h51, 1'b1);
      chk("f3_err_pulse", frame_err, 1'b1);
      chk("f3_init_none", init_out, 1'b0);
      send(8'h52, 1'b0);
      chk("f3_err_one_cycle", frame_err, 1'b0);
      send_seq(8'h53, 9, 1'b0, 1'b0);
      chk("f3_init_early", init_out, 1'b0);
      send(8'h5C, 1'b0);
      tail(8'h0E);
      chk("f3_init", init_out, 1'b1);
      byte_valid = 1'b0;
      @(negedge clk);
      chk("f3_cnt", frame_cnt, 16'd1);
      chk("f3_img000", image[0][0][0], 8'h51);
      chk("f3_img012", image[0][1][2], 8'h56);
      chk("f3_img112", image[1][1][2], 8'h5C);

`ifdef FRAME_CHECKSUM_EN
      do_reset();
      send_seq(8'h01, 12, 1'b1, 1'b0);
      send(8'h4F, 1'b0);
      chk("ck_bad_err", frame_err, 1'b1);
      chk("ck_bad_init", init_out, 1'b0);
      chk("ck_bad_ready", byte_ready, 1'b1);
      byte_valid = 1'b0;
      @(negedge clk);
      chk("ck_bad_init_after", init_out, 1'b0);
      chk("ck_bad_cnt", frame_cnt, 16'd0);
`endif

      // Reset mid-frame discards the partial frame
      do_reset();
      send_seq(8'h01, 7, 1'b1, 1'b0);
      byte_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", byte_ready, 1'b0);
      chk("mid_rst_init", init_out, 1'b0);
      chk("mid_rst_err", frame_err, 1'b0);
      chk("mid_rst_image", image_or(), 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready_after", byte_ready, 1'b1);
      chk("mid_rst_err_after", frame_err, 1'b0);
      send(8'h77, 1'b0);
      send(8'h78, 1'b0);
      send(8'h79, 1'b0);
      byte_valid = 1'b0;
      @(negedge clk);
      chk("drop_img000", image[0][0][0], 8'h00);
      chk("drop_img001", image[0][0][1], 8'h00);
      chk("drop_init", init_out, 1'b0);
      send_seq(8'h01, 12, 1'b1, 1'b0);
      tail(8'h4E);
      chk("f4_init", init_out, 1'b1);
      byte_valid = 1'b0;
      @(negedge clk);
      chk("f4_cnt", frame_cnt, 16'd1);
      chk("f4_img111", image[1][1][1], 8'h0B);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
